seq_shift_unit: RTL and testbench

- Multi-cycle shift unit for RV32 SLL/SRL/SRA (and SLLI/SRLI/SRAI).
- Shifts one bit position per clock, so a full barrel shifter is not needed.
- Complements the fixed combinational one-bit left shift used for branch/jump offsets. It adds right shifts (logical and arithmetic) and variable amounts.
- Sits beside the ALU. The execute stage uses start/busy/done to stall while a shift is in progress.

---
 rtl/seq_shift_unit_if.sv | 27 ++
 rtl/seq_shift_unit.sv | 106 ++++++++++
 tb/tb_seq_shift_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle between the execute stage and the sequential shift unit.
// The execute stage drives the request side (master); the shifter answers (slave).
`timescale 1ns/1ps

interface seq_shift_unit_if #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
);
    logic           flush;
    logic           start;
    logic [1:0]     op;
    logic [N-1:0]   data_in;
    logic [SHW-1:0] shamt;
    logic [N-1:0]   result;
    logic           busy;
    logic           done;

    modport master (
        output flush, start, op, data_in, shamt,
        input  result, busy, done
    );

    modport slave (
        input  flush, start, op, data_in, shamt,
        output result, busy, done
    );
endinterface

// File: rtl/seq_shift_unit.sv
// Multi-cycle RV32 SLL/SRL/SRA unit: one bit position per clock, start/busy/done handshake.
// Outputs come only from registers or the state decode, never straight from inputs.
`timescale 1ns/1ps

module seq_shift_unit #(
    parameter int N   = 32,
    parameter int SHW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    seq_shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_result;
    logic [1:0]     r_op;
    logic [SHW-1:0] r_count;

    logic           w_accept;
    logic           w_shift_en;
    logic [N-1:0]   w_shifted;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_shift_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // flush wins over start in the same cycle
                if (bus.start && !bus.flush) begin
                    w_accept     = 1'b1;
                    w_next_state = (bus.shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.flush) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_shift_en = 1'b1;
                    if (r_count == SHW'(1)) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Reserved op 2'b10 falls into the logical-right branch.
    always_comb begin
        w_shifted = {1'b0, r_result[N-1:1]};
        case (r_op)
            OP_SLL:  w_shifted = {r_result[N-2:0], 1'b0};
            OP_SRA:  w_shifted = {r_result[N-1], r_result[N-1:1]};
            default: w_shifted = {1'b0, r_result[N-1:1]};
        endcase
    end

    // count is only decremented in SHIFT, where it is always >= 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
            r_op     <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_result <= bus.data_in;
            r_op     <= bus.op;
            r_count  <= bus.shamt;
        end else if (w_shift_en) begin
            r_result <= w_shifted;
            r_count  <= r_count - SHW'(1);
        end
    end

    assign bus.result = r_result;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: vector table, random ops against a shift
// model, and hand-written sequences for ignored start, flush and async reset.
`timescale 1ns/1ps

module tb_seq_shift_unit;

    localparam int N   = 32;
    localparam int SHW = $clog2(N);

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] data;
        int           sh;
        logic [N-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_shift_unit_if #(.N(N)) sif();

    seq_shift_unit #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int           n_tests   = 0;
    int           n_fail    = 0;
    int           done_seen = 0;
    logic [N-1:0] sb_q[$];
    vec_t         vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] d, input int sh);
        logic signed [N-1:0] sd;
        sd = d;
        case (op)
            2'b00:   return d << sh;
            2'b11:   return sd >>> sh;
            default: return d >> sh;
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst === 1'b1 && sif.done === 1'b1) begin
            done_seen++;
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) check("result", sif.result, sb_q.pop_front());
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [N-1:0] d, input int sh,
                          input logic [N-1:0] exp);
        int n      = 0;
        int busy_n = 0;
        bit got    = 1'b0;
        @(posedge clk); #1;
        sif.start   = 1'b1;
        sif.op      = op;
        sif.data_in = d;
        sif.shamt   = SHW'(sh);
        sb_q.push_back(exp);
        @(posedge clk); #1;
        // operand changes after acceptance must not matter
        sif.start   = 1'b0;
        sif.data_in = $urandom;
        sif.op      = 2'($urandom);
        sif.shamt   = SHW'($urandom);
        while (!got && n < N + 4) begin
            @(negedge clk);
            n++;
            if (sif.busy === 1'b1) busy_n++;
            if (sif.done === 1'b1) got = 1'b1;
        end
        if (!got) sb_q.delete();
        check("latency", n, sh + 1);
        check("busy_cycles", busy_n, sh + 1);
        @(negedge clk);
        check("done_one_cycle", {31'b0, sif.done}, 32'd0);
        check("idle_after_done", {31'b0, sif.busy}, 32'd0);
        check("result_held", sif.result, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [1:0]   rop;
        logic [N-1:0] rd;
        int           rsh;

        vecs[0]  = '{2'b11, 32'h8000_0000,  4, 32'hF800_0000};
        vecs[1]  = '{2'b01, 32'h8000_0000,  4, 32'h0800_0000};
        vecs[2]  = '{2'b00, 32'h0000_0001, 31, 32'h8000_0000};
        vecs[3]  = '{2'b00, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF};
        vecs[4]  = '{2'b01, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF};
        vecs[5]  = '{2'b11, 32'hDEAD_BEEF,  0, 32'hDEAD_BEEF};
        vecs[6]  = '{2'b10, 32'h8000_0000,  4, 32'h0800_0000};
        vecs[7]  = '{2'b11, 32'h7FFF_FFFF, 31, 32'h0000_0000};
        vecs[8]  = '{2'b11, 32'h8000_0000, 31, 32'hFFFF_FFFF};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF, 31, 32'h0000_0001};
        vecs[10] = '{2'b00, 32'h1234_5678,  4, 32'h2345_6780};
        vecs[11] = '{2'b11, 32'h4000_0001,  1, 32'h2000_0000};

        rst         = 1'b0;
        sif.flush   = 1'b0;
        sif.start   = 1'b0;
        sif.op      = 2'b00;
        sif.data_in = '0;
        sif.shamt   = '0;

        @(negedge clk);
        check("rst_result", sif.result, 32'd0);
        check("rst_busy", {31'b0, sif.busy}, 32'd0);
        check("rst_done", {31'b0, sif.done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].data, vecs[i].sh, vecs[i].exp);
        end

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom);
            rd  = $urandom;
            rsh = $urandom_range(0, N - 1);
            run_op(rop, rd, rsh, model(rop, rd, rsh));
        end

        // Start re-asserted mid-shift (cycle 3) and in DONE (cycle 9): both ignored.
        d0 = done_seen;
        @(posedge clk); #1;
        sif.start = 1'b1; sif.op = 2'b01; sif.data_in = 32'h0000_F000; sif.shamt = SHW'(8);
        sb_q.push_back(32'h0000_00F0);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            sif.start   = (c == 3 || c == 9);
            sif.data_in = (c == 3 || c == 9) ? 32'hFFFF_FFFF : $urandom;
            sif.op      = 2'b00;
            sif.shamt   = SHW'(3);
        end
        sif.start = 1'b0;
        @(negedge clk);
        check("ign_single_done", done_seen - d0, 32'd1);
        check("ign_not_queued", {31'b0, sif.busy}, 32'd0);
        check("ign_result", sif.result, 32'h0000_00F0);
        run_op(2'b00, 32'hFFFF_FFFF, 3, 32'hFFFF_FFF8);

        // Flush mid-shift together with start: abort, no done, start not taken.
        d0 = done_seen;
        @(posedge clk); #1;
        sif.start = 1'b1; sif.op = 2'b11; sif.data_in = 32'h8000_0000; sif.shamt = SHW'(10);
        sb_q.push_back(32'hFFE0_0000);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            sif.start = (c == 4);
            sif.flush = (c == 4);
            sif.data_in = 32'h1234_5678;
            sif.shamt   = SHW'(2);
        end
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        sif.start = 1'b0;
        sif.flush = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'b0, sif.busy}, 32'd0);
        check("flush_done", {31'b0, sif.done}, 32'd0);
        repeat (4) @(negedge clk);
        check("flush_no_done", done_seen - d0, 32'd0);
        run_op(2'b11, 32'h8000_0000, 10, 32'hFFE0_0000);

        // Flush and start together in IDLE: flush wins.
        d0 = done_seen;
        @(posedge clk); #1;
        sif.start = 1'b1; sif.flush = 1'b1; sif.op = 2'b01; sif.data_in = 32'h5555_5555;
        sif.shamt = SHW'(3);
        @(posedge clk); #1;
        sif.start = 1'b0; sif.flush = 1'b0;
        @(negedge clk);
        check("idle_flush_busy", {31'b0, sif.busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("idle_flush_no_done", done_seen - d0, 32'd0);

        // Asynchronous reset between clock edges in the middle of SHIFT.
        @(posedge clk); #1;
        sif.start = 1'b1; sif.op = 2'b00; sif.data_in = 32'h0000_0001; sif.shamt = SHW'(20);
        sb_q.push_back(32'h0010_0000);
        @(posedge clk); #1;
        sif.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst_busy", {31'b0, sif.busy}, 32'd1);
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("arst_result", sif.result, 32'd0);
        check("arst_busy", {31'b0, sif.busy}, 32'd0);
        check("arst_done", {31'b0, sif.done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_idle", {31'b0, sif.busy}, 32'd0);
        end
        run_op(2'b00, 32'h0000_0001, 20, 32'h0010_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
